// File: rtl/mutative_fill_controller.sv
// Cache miss handler: picks a victim way, optionally writes back a dirty line, then refills from memory.
// The dirty writeback path is compiled only when MUTATIVE_FILL_WRITEBACK_EN is defined.
module mutative_fill_controller #(
   parameter int WAYS     = 8,
   parameter int TAG_BITS = 24
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          miss_req,
   input  logic [31:0]                   miss_addr,
   input  logic [1:0]                    setup,
   input  logic [WAYS-1:0]               way_valid,
   input  logic [WAYS-1:0]               way_dirty,
   input  logic [WAYS-1:0][TAG_BITS-1:0] way_tag,
   input  logic [255:0]                  victim_data,
   output logic [31:0]                   dfp_addr,
   output logic                          dfp_read,
   output logic                          dfp_write,
   output logic [255:0]                  dfp_wdata,
   input  logic [255:0]                  dfp_rdata,
   input  logic                          dfp_resp,
   output logic [WAYS-1:0]               fill_web,
   output logic [255:0]                  fill_data,
   output logic [TAG_BITS-1:0]           fill_tag,
   output logic                          fill_valid,
   output logic [2:0]                    victim_way,
   output logic                          miss_done
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SELECT    = 3'd1;
   localparam logic [2:0] WRITEBACK = 3'd2;
   localparam logic [2:0] ALLOCATE  = 3'd3;
   localparam logic [2:0] FILL      = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;

   logic [2:0]   state;
   logic [2:0]   rr;
   logic [2:0]   victim_r;
   logic [31:5]  addr_r;
   logic [255:0] line_r;

   logic [2:0]   tag_lo;
   logic [2:0]   grp_base;
   logic [2:0]   grp_mask;
   logic [2:0]   sel_victim;
   logic         sel_writeback;

   assign tag_lo = miss_addr[34-TAG_BITS:32-TAG_BITS];

   // Candidate group is an aligned block of 1/2/4/8 ways; first invalid way wins, else round-robin.
   always_comb begin
      grp_base = 3'd0;
      grp_mask = 3'd7;
      case (setup)
         2'd0:    begin grp_base = tag_lo;                grp_mask = 3'd0; end
         2'd1:    begin grp_base = {tag_lo[2:1], 1'b0};   grp_mask = 3'd1; end
         2'd2:    begin grp_base = {tag_lo[2], 2'b00};    grp_mask = 3'd3; end
         default: begin grp_base = 3'd0;                  grp_mask = 3'd7; end
      endcase
      sel_victim = grp_base + (rr & grp_mask);
      for (int k = 7; k >= 0; k--) begin
         if ((3'(k) <= grp_mask) && !way_valid[grp_base + 3'(k)])
            sel_victim = grp_base + 3'(k);
      end
   end

`ifdef MUTATIVE_FILL_WRITEBACK_EN
   assign sel_writeback = way_valid[sel_victim] & way_dirty[sel_victim];
`else
   logic unused_dirty;
   assign sel_writeback = 1'b0;
   assign unused_dirty  = ^way_dirty;
`endif

   // setup and the line offset only matter through the victim and line address captured in SELECT
   logic unused_offset;
   assign unused_offset = ^miss_addr[4:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr       <= 3'd0;
         victim_r <= 3'd0;
         addr_r   <= '0;
         line_r   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_req)
                  state <= SELECT;
            end
            SELECT: begin
               victim_r <= sel_victim;
               addr_r   <= miss_addr[31:5];
               state    <= sel_writeback ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
               if (dfp_resp)
                  state <= ALLOCATE;
            end
            ALLOCATE: begin
               if (dfp_resp) begin
                  line_r <= dfp_rdata;
                  state  <= FILL;
               end
            end
            FILL: begin
               state <= DONE;
            end
            DONE: begin
               rr    <= rr + 3'd1;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // All outputs decode from state so reset clears them immediately
   always_comb begin
      dfp_read   = (state == ALLOCATE);
`ifdef MUTATIVE_FILL_WRITEBACK_EN
      dfp_write  = (state == WRITEBACK);
`else
      dfp_write  = 1'b0;
`endif
      dfp_addr   = 32'd0;
      dfp_wdata  = '0;
      fill_web   = '1;
      fill_data  = '0;
      fill_tag   = '0;
      fill_valid = 1'b0;
      miss_done  = (state == DONE);
      if (state == WRITEBACK) begin
         dfp_addr  = {way_tag[victim_r], addr_r[31-TAG_BITS:5], 5'b00000};
         dfp_wdata = victim_data;
      end
      if (state == ALLOCATE)
         dfp_addr = {addr_r, 5'b00000};
      if (state == FILL) begin
         fill_web[victim_r] = 1'b0;
         fill_data          = line_r;
         fill_tag           = addr_r[31:32-TAG_BITS];
         fill_valid         = 1'b1;
      end
   end

   assign victim_way = victim_r;

endmodule
